// File: rtl/uart_apb_tx_ctrl.sv
// APB master that initialises a 16550-style UART and then drains a byte FIFO into THR.
// Optional macro UART_TX_CTRL_THRE_POLL_EN gates every THR write on an LSR.THRE read.
module uart_apb_tx_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [15:0] DIVISOR    = 16'h0001,
    parameter logic [7:0]  LCR_VALUE  = 8'h03,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    output logic        tx_ready_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        init_done_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        INIT_DLAB,
        INIT_DLL,
        INIT_DLM,
        INIT_LCR,
        INIT_FCR,
        IDLE,
`ifdef UART_TX_CTRL_THRE_POLL_EN
        POLL,
        POLL_GAP,
`endif
        TX
    } state_t;

`ifdef UART_TX_CTRL_THRE_POLL_EN
    localparam state_t DRAIN_STATE = POLL;
`else
    localparam state_t DRAIN_STATE = TX;
`endif

    // byte FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [7:0]       head;

    assign tx_ready_o = (count != CNT_W'(FIFO_DEPTH));
    assign push       = tx_valid_i & tx_ready_o;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= tx_data_i;
    end

    // FSM and registered APB outputs
    state_t      state;
    state_t      state_nx;
    state_t      load_state;
    logic        psel_q, penable_q, pwrite_q;
    logic        psel_d, penable_d, pwrite_d;
    logic [31:0] paddr_q, pwdata_q, paddr_d, pwdata_d;
    logic [3:0]  pstrb_q, pstrb_d;
    logic        init_done_q, init_done_d;
    logic        err_q, err_d;
    logic        complete;
    logic        start;

    logic [2:0]  op_ofs;
    logic [7:0]  op_byte;
    logic        op_write;
    logic [31:0] op_addr;
    logic [31:0] op_data;
    logic [3:0]  op_strb;

    assign complete = psel_q & penable_q & pready_i;

`ifdef UART_TX_CTRL_THRE_POLL_EN
    logic [31:0] rd_word;
    logic        thre;
    logic        unused_rd;
    assign rd_word   = prdata_i >> {paddr_q[1:0], 3'b000};
    assign thre      = rd_word[5];
    assign unused_rd = ^{rd_word[31:6], rd_word[4:0]};
`else
    logic        unused_rd;
    assign unused_rd = ^prdata_i;
`endif

    // IDLE and POLL_GAP launch the next transfer directly so no extra gap cycle is spent
    always_comb begin
        load_state = state;
        if (state == IDLE) load_state = DRAIN_STATE;
`ifdef UART_TX_CTRL_THRE_POLL_EN
        if (state == POLL_GAP) load_state = POLL;
`endif
    end

    always_comb begin
        op_ofs   = 3'd0;
        op_byte  = 8'h00;
        op_write = 1'b1;
        case (load_state)
            INIT_DLAB: begin op_ofs = 3'd3; op_byte = 8'h80;            end
            INIT_DLL:  begin op_ofs = 3'd0; op_byte = DIVISOR[7:0];     end
            INIT_DLM:  begin op_ofs = 3'd1; op_byte = DIVISOR[15:8];    end
            INIT_LCR:  begin op_ofs = 3'd3; op_byte = LCR_VALUE & 8'h7F; end
            INIT_FCR:  begin op_ofs = 3'd2; op_byte = 8'h07;            end
`ifdef UART_TX_CTRL_THRE_POLL_EN
            POLL:      begin op_ofs = 3'd5; op_write = 1'b0;            end
`endif
            TX:        begin op_ofs = 3'd0; op_byte = head;             end
            default:   begin op_ofs = 3'd0;                             end
        endcase
        op_addr = BASE_ADDR + {29'd0, op_ofs};
        op_data = {24'd0, op_byte} << {op_addr[1:0], 3'b000};
        op_strb = 4'b0001 << op_addr[1:0];
    end

    always_comb begin
        state_nx    = state;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        init_done_d = init_done_q;
        err_d       = err_q | (complete & pslverr_i);
        pop         = 1'b0;
        start       = 1'b0;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = DRAIN_STATE;
                    start    = 1'b1;
                end
            end
`ifdef UART_TX_CTRL_THRE_POLL_EN
            POLL_GAP: begin
                state_nx = POLL;
                start    = 1'b1;
            end
`endif
            default: begin
                if (!psel_q) begin
                    start = 1'b1;
                end else if (!penable_q) begin
                    penable_d = 1'b1;
                end else if (pready_i) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    case (state)
                        INIT_DLAB: state_nx = INIT_DLL;
                        INIT_DLL:  state_nx = INIT_DLM;
                        INIT_DLM:  state_nx = INIT_LCR;
                        INIT_LCR:  state_nx = INIT_FCR;
                        INIT_FCR: begin
                            state_nx    = IDLE;
                            init_done_d = 1'b1;
                        end
`ifdef UART_TX_CTRL_THRE_POLL_EN
                        POLL:      state_nx = thre ? TX : POLL_GAP;
`endif
                        TX: begin
                            state_nx = IDLE;
                            pop      = 1'b1;
                        end
                        default:   state_nx = IDLE;
                    endcase
                end
            end
        endcase

        if (start) begin
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = op_write;
            paddr_d   = op_addr;
            pwdata_d  = op_data;
            pstrb_d   = op_strb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= INIT_DLAB;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    assign psel_o      = psel_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign pstrb_o     = pstrb_q;
    assign init_done_o = init_done_q;
    assign err_o       = err_q;
    assign busy_o      = (count != '0) | psel_q;

endmodule

// File: tb/tb_uart_apb_tx_ctrl.sv
// Directed bench for uart_apb_tx_ctrl: init order, byte ordering, backpressure, errors, reset.
`timescale 1ns/1ps
module tb_uart_apb_tx_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_ready;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic        init_done, busy, err;

    int total = 0;
    int bad = 0;

    uart_apb_tx_ctrl #(
        .BASE_ADDR (32'h0000_0000),
        .DIVISOR   (16'h0102),
        .LCR_VALUE (8'h83),
        .FIFO_DEPTH(4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tx_valid_i (tx_valid),
        .tx_data_i  (tx_data),
        .tx_ready_o (tx_ready),
        .psel_o     (psel),
        .penable_o  (penable),
        .pwrite_o   (pwrite),
        .paddr_o    (paddr),
        .pwdata_o   (pwdata),
        .pstrb_o    (pstrb),
        .prdata_i   (prdata),
        .pready_i   (pready),
        .pslverr_i  (pslverr),
        .init_done_o(init_done),
        .busy_o     (busy),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // slave model
    int   acc_cnt = 0;
    int   wait_states = 0;
    bit   pready_en = 1'b1;
    bit   hold_writes = 1'b0;
    bit   slverr_en = 1'b0;
    bit   lsr_arm = 1'b0;
    int   lsr_base = 0;
    int   rd_count = 0;
    logic [7:0] lsr_cur;

    assign pready  = pready_en && !(hold_writes && pwrite) && (acc_cnt >= wait_states);
    assign pslverr = slverr_en && psel && penable && pwrite && (pwdata[7:0] == 8'hA1);
    assign lsr_cur = (lsr_arm && (rd_count - lsr_base) < 2) ? 8'h00 : 8'h60;
    assign prdata  = {16'h0000, lsr_cur, 8'h00};

    // transfer log
    logic [31:0] w_addr [32];
    logic [31:0] w_data [32];
    logic [3:0]  w_strb [32];
    int          w_len  [32];
    bit          w_stab [32];
    bit          w_idone[32];
    int          w_cyc  [32];
    int          wn = 0;
    logic [31:0] r_addr [32];
    logic [3:0]  r_strb [32];
    int          r_cyc  [32];
    int          rn = 0;
    int          cyc = 0;
    logic [31:0] a0, d0;
    int          len = 0;
    bit          stab = 1'b1;

    always @(posedge clk) begin
        int  len_now;
        bit  stab_now;
        cyc = cyc + 1;
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && !penable) begin
            a0 = paddr; d0 = pwdata; len = 0; stab = 1'b1;
        end else if (psel && penable) begin
            len_now  = len + 1;
            stab_now = stab && (paddr == a0) && (pwdata == d0);
            len  = len_now;
            stab = stab_now;
            if (pready) begin
                if (pwrite) begin
                    if (wn < 32) begin
                        w_addr[wn] = paddr; w_data[wn] = pwdata; w_strb[wn] = pstrb;
                        w_len[wn] = len_now; w_stab[wn] = stab_now;
                        w_idone[wn] = init_done; w_cyc[wn] = cyc;
                    end
                    wn = wn + 1;
                end else begin
                    if (rn < 32) begin
                        r_addr[rn] = paddr; r_strb[rn] = pstrb; r_cyc[rn] = cyc;
                    end
                    rn = rn + 1;
                    rd_count <= rd_count + 1;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string name);
        int n = 0;
        while (wn < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (wn < target) begin
            $display("FAIL %s timeout: writes=%0d required=%0d", name, wn, target);
            bad++;
        end
        total++;
    endtask

    task automatic test_reset();
        #12;
        total += 10;
        if (psel !== 1'b0)       begin $display("FAIL rst_psel got=%b exp=0", psel); bad++; end
        if (penable !== 1'b0)    begin $display("FAIL rst_penable got=%b exp=0", penable); bad++; end
        if (pwrite !== 1'b0)     begin $display("FAIL rst_pwrite got=%b exp=0", pwrite); bad++; end
        if (paddr !== 32'h0)     begin $display("FAIL rst_paddr got=%h exp=0", paddr); bad++; end
        if (pwdata !== 32'h0)    begin $display("FAIL rst_pwdata got=%h exp=0", pwdata); bad++; end
        if (pstrb !== 4'h0)      begin $display("FAIL rst_pstrb got=%h exp=0", pstrb); bad++; end
        if (init_done !== 1'b0)  begin $display("FAIL rst_init_done got=%b exp=0", init_done); bad++; end
        if (busy !== 1'b0)       begin $display("FAIL rst_busy got=%b exp=0", busy); bad++; end
        if (err !== 1'b0)        begin $display("FAIL rst_err got=%b exp=0", err); bad++; end
        if (tx_ready !== 1'b1)   begin $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); bad++; end
    endtask

    task automatic test_init_and_order();
        logic [31:0] exp_addr [5] = '{32'd3, 32'd0, 32'd1, 32'd3, 32'd2};
        logic [31:0] exp_data [5] = '{32'h8000_0000, 32'h0000_0002, 32'h0000_0100,
                                      32'h0300_0000, 32'h0007_0000};
        logic [3:0]  exp_strb [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100};
        logic [31:0] exp_byte [3] = '{32'h41, 32'h42, 32'h43};
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        wait_writes(8, "thr_abc");
        total++;
        if (busy !== 1'b0) begin $display("FAIL busy_after_last got=%b exp=0", busy); bad++; end
        for (int i = 0; i < 5; i++) begin
            total += 4;
            if (w_addr[i] !== exp_addr[i]) begin
                $display("FAIL init%0d_addr got=%h exp=%h", i, w_addr[i], exp_addr[i]); bad++; end
            if (w_data[i] !== exp_data[i]) begin
                $display("FAIL init%0d_data got=%h exp=%h", i, w_data[i], exp_data[i]); bad++; end
            if (w_strb[i] !== exp_strb[i]) begin
                $display("FAIL init%0d_strb got=%b exp=%b", i, w_strb[i], exp_strb[i]); bad++; end
            if (w_idone[i] !== 1'b0) begin
                $display("FAIL init%0d_done_early got=%b exp=0", i, w_idone[i]); bad++; end
        end
        total++;
        if (init_done !== 1'b1) begin $display("FAIL init_done got=%b exp=1", init_done); bad++; end
        for (int i = 0; i < 3; i++) begin
            total += 3;
            if (w_addr[5+i] !== 32'h0) begin
                $display("FAIL thr%0d_addr got=%h exp=0", i, w_addr[5+i]); bad++; end
            if (w_data[5+i] !== exp_byte[i]) begin
                $display("FAIL thr%0d_data got=%h exp=%h", i, w_data[5+i], exp_byte[i]); bad++; end
            if (w_strb[5+i] !== 4'b0001) begin
                $display("FAIL thr%0d_strb got=%b exp=0001", i, w_strb[5+i]); bad++; end
        end
`ifndef UART_TX_CTRL_THRE_POLL_EN
        total += 2;
        if (w_cyc[6] - w_cyc[5] != 3) begin
            $display("FAIL thr_rate01 got=%0d exp=3", w_cyc[6] - w_cyc[5]); bad++; end
        if (w_cyc[7] - w_cyc[6] != 3) begin
            $display("FAIL thr_rate12 got=%0d exp=3", w_cyc[7] - w_cyc[6]); bad++; end
`endif
    endtask

`ifdef UART_TX_CTRL_THRE_POLL_EN
    task automatic test_poll();
        int rn0 = rn;
        int wn0 = wn;
        @(negedge clk);
        lsr_base = rd_count;
        lsr_arm  = 1'b1;
        push(8'h55);
        wait_writes(wn0 + 1, "poll_write");
        lsr_arm = 1'b0;
        total += 3;
        if (rn - rn0 != 3) begin $display("FAIL poll_reads got=%0d exp=3", rn - rn0); bad++; end
        if (w_data[wn0] !== 32'h55) begin
            $display("FAIL poll_thr_data got=%h exp=55", w_data[wn0]); bad++; end
        if (w_addr[wn0] !== 32'h0) begin
            $display("FAIL poll_thr_addr got=%h exp=0", w_addr[wn0]); bad++; end
        for (int k = 0; k < 3; k++) begin
            total += 2;
            if (r_addr[rn0+k] !== 32'd5) begin
                $display("FAIL poll%0d_addr got=%h exp=5", k, r_addr[rn0+k]); bad++; end
            if (r_strb[rn0+k] !== 4'b0010) begin
                $display("FAIL poll%0d_strb got=%b exp=0010", k, r_strb[rn0+k]); bad++; end
        end
        for (int k = 1; k < 3; k++) begin
            total++;
            if (r_cyc[rn0+k] - r_cyc[rn0+k-1] != 3) begin
                $display("FAIL poll%0d_gap got=%0d exp=3", k, r_cyc[rn0+k] - r_cyc[rn0+k-1]); bad++; end
        end
    endtask
`endif

    task automatic test_full();
        int wn0 = wn;
        int n = 0;
        logic [31:0] exp_b [4] = '{32'h10, 32'h11, 32'h12, 32'h13};
        @(negedge clk);
        pready_en = 1'b0;
        push(8'h10);
        push(8'h11);
        push(8'h12);
        push(8'h13);
        total++;
        if (tx_ready !== 1'b0) begin $display("FAIL full_ready got=%b exp=0", tx_ready); bad++; end
        push(8'h99);
        total++;
        if (tx_ready !== 1'b0) begin $display("FAIL full_fifth got=%b exp=0", tx_ready); bad++; end
        pready_en = 1'b1;
        while (wn == wn0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_ready !== 1'b1) begin $display("FAIL full_ready_after_pop got=%b exp=1", tx_ready); bad++; end
        wait_writes(wn0 + 4, "full_drain");
        for (int i = 0; i < 4; i++) begin
            total++;
            if (w_data[wn0+i] !== exp_b[i]) begin
                $display("FAIL full%0d_data got=%h exp=%h", i, w_data[wn0+i], exp_b[i]); bad++; end
        end
        repeat (12) @(negedge clk);
        total++;
        if (wn != wn0 + 4) begin $display("FAIL full_extra_writes got=%0d exp=%0d", wn - wn0, 4); bad++; end
    endtask

    task automatic test_slverr();
        int wn0 = wn;
        total++;
        if (err !== 1'b0) begin $display("FAIL err_before got=%b exp=0", err); bad++; end
        @(negedge clk);
        wait_states = 3;
        slverr_en   = 1'b1;
        push(8'hA1);
        push(8'hA2);
        wait_writes(wn0 + 2, "slverr_writes");
        total += 7;
        if (w_data[wn0] !== 32'hA1)   begin $display("FAIL err_b0_data got=%h exp=a1", w_data[wn0]); bad++; end
        if (w_len[wn0] != 4)          begin $display("FAIL err_b0_penable_len got=%0d exp=4", w_len[wn0]); bad++; end
        if (w_stab[wn0] !== 1'b1)     begin $display("FAIL err_b0_stable got=%b exp=1", w_stab[wn0]); bad++; end
        if (w_data[wn0+1] !== 32'hA2) begin $display("FAIL err_b1_data got=%h exp=a2", w_data[wn0+1]); bad++; end
        if (w_len[wn0+1] != 4)        begin $display("FAIL err_b1_penable_len got=%0d exp=4", w_len[wn0+1]); bad++; end
        if (err !== 1'b1)             begin $display("FAIL err_sticky got=%b exp=1", err); bad++; end
        if (busy !== 1'b0)            begin $display("FAIL err_busy got=%b exp=0", busy); bad++; end
        wait_states = 0;
        slverr_en   = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if (err !== 1'b1) begin $display("FAIL err_sticky_later got=%b exp=1", err); bad++; end
    endtask

    task automatic test_reset_mid();
        int wn0;
        int n = 0;
        @(negedge clk);
        hold_writes = 1'b1;
        wn0 = wn;
        push(8'hB1);
        push(8'hB2);
        while (!(psel && penable && pwrite) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(psel && penable && pwrite)) begin
            $display("FAIL rmid_access timeout: psel=%b penable=%b exp=1,1", psel, penable); bad++; end
        #2 rst_n = 1'b0;
        #1;
        total += 5;
        if (psel !== 1'b0)      begin $display("FAIL rmid_psel got=%b exp=0", psel); bad++; end
        if (penable !== 1'b0)   begin $display("FAIL rmid_penable got=%b exp=0", penable); bad++; end
        if (busy !== 1'b0)      begin $display("FAIL rmid_busy got=%b exp=0", busy); bad++; end
        if (tx_ready !== 1'b1)  begin $display("FAIL rmid_ready got=%b exp=1", tx_ready); bad++; end
        if (init_done !== 1'b0) begin $display("FAIL rmid_init_done got=%b exp=0", init_done); bad++; end
        @(negedge clk);
        rst_n       = 1'b1;
        hold_writes = 1'b0;
        @(negedge clk);
        total += 4;
        if (psel !== 1'b1 || penable !== 1'b0) begin
            $display("FAIL rmid_setup got=%b%b exp=10", psel, penable); bad++; end
        if (paddr !== 32'd3)          begin $display("FAIL rmid_addr got=%h exp=3", paddr); bad++; end
        if (pwdata !== 32'h8000_0000) begin $display("FAIL rmid_data got=%h exp=80000000", pwdata); bad++; end
        if (pstrb !== 4'b1000)        begin $display("FAIL rmid_strb got=%b exp=1000", pstrb); bad++; end
        wait_writes(wn0 + 5, "rmid_init");
        repeat (15) @(negedge clk);
        total += 3;
        if (wn != wn0 + 5)       begin $display("FAIL rmid_flushed got=%0d exp=5", wn - wn0); bad++; end
        if (w_data[wn0] !== 32'h8000_0000) begin
            $display("FAIL rmid_first_data got=%h exp=80000000", w_data[wn0]); bad++; end
        if (init_done !== 1'b1)  begin $display("FAIL rmid_done got=%b exp=1", init_done); bad++; end
    endtask

    initial begin
        test_reset();
        test_init_and_order();
`ifdef UART_TX_CTRL_THRE_POLL_EN
        test_poll();
`endif
        test_full();
        test_slverr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
